// File: rtl/audio_clken_gen_if.sv
// Configuration port of audio_clken_gen: a valid/ready load of one channel's INC/MOD
// pair, with a one-cycle error flag returned while the load is being applied.
interface audio_clken_gen_if #(
   parameter int CHAN_W = 1,
   parameter int ACC_W  = 32
);
   logic              cfg_valid;
   logic              cfg_ready;
   logic [CHAN_W-1:0] cfg_chan;
   logic [ACC_W-1:0]  cfg_inc;
   logic [ACC_W-1:0]  cfg_mod;
   logic              cfg_err;

   modport master (output cfg_valid, cfg_chan, cfg_inc, cfg_mod,
                   input  cfg_ready, cfg_err);
   modport slave  (input  cfg_valid, cfg_chan, cfg_inc, cfg_mod,
                   output cfg_ready, cfg_err);
endinterface

// File: rtl/audio_clken_gen.sv
// Multi-channel fractional clock-enable generator. Each channel runs a phase accumulator
// producing INC enable pulses per MOD refclk cycles, and reports locked once it has produced
// LOCK_PULSES pulses since its last load.
// Optional feature: define AUDCLK_SQUARE_OUT_EN to build the clk_sq square-wave outputs
// (one toggle per ce pulse).
//
// Config FSM:
//   state     | meaning
//   CFG_IDLE  | cfg_ready high, waiting for a transfer
//   CFG_APPLY | captured load written to its channel this cycle, cfg_err valid
// Channel FSM:
//   state       | meaning
//   CH_DISABLED | last load had an illegal ratio; no pulses
//   CH_SETTLING | stepping, fewer than LOCK_PULSES pulses since load
//   CH_LOCKED   | stepping and settled
module audio_clken_gen #(
   parameter int          CHANNELS    = 2,
   parameter int          ACC_W       = 32,
   parameter int unsigned DEF_INC     = 12288,
   parameter int unsigned DEF_MOD     = 25000,
   parameter int          LOCK_PULSES = 16
) (
   input  logic                refclk,
   input  logic                rst_n,
   audio_clken_gen_if.slave    cfg,
   output logic [CHANNELS-1:0] ce,
   output logic [CHANNELS-1:0] locked
`ifdef AUDCLK_SQUARE_OUT_EN
   ,
   output logic [CHANNELS-1:0] clk_sq
`endif
);

   localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   typedef enum logic {
      CFG_IDLE,
      CFG_APPLY
   } cfg_state_t;

   typedef enum logic [1:0] {
      CH_DISABLED,
      CH_SETTLING,
      CH_LOCKED
   } ch_state_t;

   cfg_state_t        cfg_state_q, cfg_state_d;
   logic [CHAN_W-1:0] chan_q, chan_d;
   logic [ACC_W-1:0]  ld_inc_q, ld_inc_d;
   logic [ACC_W-1:0]  ld_mod_q, ld_mod_d;
   logic              apply;
   logic              bad_chan;
   logic              bad_ratio;

   ch_state_t           st_q  [CHANNELS];
   ch_state_t           st_d  [CHANNELS];
   logic [ACC_W-1:0]    acc_q [CHANNELS];
   logic [ACC_W-1:0]    acc_d [CHANNELS];
   logic [ACC_W-1:0]    inc_q [CHANNELS];
   logic [ACC_W-1:0]    inc_d [CHANNELS];
   logic [ACC_W-1:0]    mod_q [CHANNELS];
   logic [ACC_W-1:0]    mod_d [CHANNELS];
   logic [15:0]         cnt_q [CHANNELS];
   logic [15:0]         cnt_d [CHANNELS];
   logic [CHANNELS-1:0] ce_q, ce_d;
   logic [CHANNELS-1:0] wrap;
   logic [CHANNELS-1:0] hit;

   assign apply     = (cfg_state_q == CFG_APPLY);
   assign bad_chan  = 32'(chan_q) >= 32'(CHANNELS);
   assign bad_ratio = (ld_inc_q == '0) || (ld_inc_q >= ld_mod_q);

   // config FSM: capture on transfer, write the channel in the following cycle
   always_comb begin
      cfg_state_d   = cfg_state_q;
      chan_d        = chan_q;
      ld_inc_d      = ld_inc_q;
      ld_mod_d      = ld_mod_q;
      cfg.cfg_ready = 1'b0;
      cfg.cfg_err   = 1'b0;
      case (cfg_state_q)
         CFG_IDLE: begin
            cfg.cfg_ready = 1'b1;
            if (cfg.cfg_valid) begin
               chan_d      = cfg.cfg_chan;
               ld_inc_d    = cfg.cfg_inc;
               ld_mod_d    = cfg.cfg_mod;
               cfg_state_d = CFG_APPLY;
            end
         end
         CFG_APPLY: begin
            cfg.cfg_err = bad_chan | bad_ratio;
            cfg_state_d = CFG_IDLE;
         end
         default: cfg_state_d = CFG_IDLE;
      endcase
   end

   // config state and captured load
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_state_q <= CFG_IDLE;
         chan_q      <= '0;
         ld_inc_q    <= '0;
         ld_mod_q    <= '0;
      end else begin
         cfg_state_q <= cfg_state_d;
         chan_q      <= chan_d;
         ld_inc_q    <= ld_inc_d;
         ld_mod_q    <= ld_mod_d;
      end
   end

   // wrap detection at ACC_W+1 bits, and which channel the current apply targets
   always_comb begin
      wrap = '0;
      hit  = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         wrap[ch] = ({1'b0, acc_q[ch]} + {1'b0, inc_q[ch]}) >= {1'b0, mod_q[ch]};
         hit[ch]  = apply && !bad_chan && (32'(chan_q) == 32'(ch));
      end
   end

   // per-channel step and FSM; a load overrides the channel's own step
   always_comb begin
      ce_d = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         st_d[ch]  = st_q[ch];
         acc_d[ch] = acc_q[ch];
         inc_d[ch] = inc_q[ch];
         mod_d[ch] = mod_q[ch];
         cnt_d[ch] = cnt_q[ch];
         if (hit[ch]) begin
            acc_d[ch] = '0;
            cnt_d[ch] = '0;
            if (bad_ratio) begin
               st_d[ch] = CH_DISABLED;
            end else begin
               inc_d[ch] = ld_inc_q;
               mod_d[ch] = ld_mod_q;
               st_d[ch]  = CH_SETTLING;
            end
         end else if (st_q[ch] != CH_DISABLED) begin
            // acc < MOD is invariant, so the ACC_W-bit difference is exact
            if (wrap[ch]) begin
               acc_d[ch] = acc_q[ch] + inc_q[ch] - mod_q[ch];
               ce_d[ch]  = 1'b1;
               if (cnt_q[ch] != 16'hFFFF) begin
                  cnt_d[ch] = cnt_q[ch] + 16'd1;
               end
            end else begin
               acc_d[ch] = acc_q[ch] + inc_q[ch];
            end
            if ((st_q[ch] == CH_SETTLING) && (cnt_q[ch] >= 16'(LOCK_PULSES))) begin
               st_d[ch] = CH_LOCKED;
            end
         end
      end
   end

   // per-channel state registers
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         ce_q <= '0;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            st_q[ch]  <= CH_SETTLING;
            acc_q[ch] <= '0;
            inc_q[ch] <= ACC_W'(DEF_INC);
            mod_q[ch] <= ACC_W'(DEF_MOD);
            cnt_q[ch] <= '0;
         end
      end else begin
         ce_q <= ce_d;
         for (int ch = 0; ch < CHANNELS; ch++) begin
            st_q[ch]  <= st_d[ch];
            acc_q[ch] <= acc_d[ch];
            inc_q[ch] <= inc_d[ch];
            mod_q[ch] <= mod_d[ch];
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   // locked is decoded straight from the registered channel state
   always_comb begin
      locked = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         locked[ch] = (st_q[ch] == CH_LOCKED);
      end
   end

   assign ce = ce_q;

`ifdef AUDCLK_SQUARE_OUT_EN
   logic [CHANNELS-1:0] sq_q, sq_d;

   // toggle with every registered ce; cleared by any load and frozen at 0 while disabled
   always_comb begin
      sq_d = sq_q;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if (hit[ch]) begin
            sq_d[ch] = 1'b0;
         end else if ((st_q[ch] != CH_DISABLED) && wrap[ch]) begin
            sq_d[ch] = ~sq_q[ch];
         end
      end
   end

   // square-wave register
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         sq_q <= '0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign clk_sq = sq_q;
`endif

endmodule

// File: tb/tb_audio_clken_gen.sv
// Bench for audio_clken_gen. Three channels so that an out-of-range channel index exists.
// The reference model uses the closed form: after k steps since start, a channel has emitted
// floor(k*INC/MOD) pulses.
module tb_audio_clken_gen;

   localparam int              CH    = 3;
   localparam int              CW    = 2;
   localparam int              ACC_W = 32;
   localparam int              LOCK  = 16;
   localparam longint unsigned D_INC = 12288;
   localparam longint unsigned D_MOD = 25000;

   logic          refclk = 1'b0;
   logic          rst_n  = 1'b1;
   logic [CH-1:0] ce;
   logic [CH-1:0] locked;
`ifdef AUDCLK_SQUARE_OUT_EN
   logic [CH-1:0] clk_sq;
`endif

   audio_clken_gen_if #(.CHAN_W(CW), .ACC_W(ACC_W)) cfg_if ();

   audio_clken_gen #(
      .CHANNELS    (CH),
      .ACC_W       (ACC_W),
      .DEF_INC     (12288),
      .DEF_MOD     (25000),
      .LOCK_PULSES (LOCK)
   ) dut (
      .refclk (refclk),
      .rst_n  (rst_n),
      .cfg    (cfg_if),
      .ce     (ce),
      .locked (locked)
`ifdef AUDCLK_SQUARE_OUT_EN
      ,
      .clk_sq (clk_sq)
`endif
   );

   always #5 refclk = ~refclk;

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_on  = 1'b0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit              m_en  [CH];
   longint unsigned m_inc [CH];
   longint unsigned m_mod [CH];
   longint unsigned m_k   [CH];
   bit              m_pend;
   logic [CW-1:0]   m_chan;
   longint unsigned m_ld_inc, m_ld_mod;
   logic [CH-1:0]   e_ce, e_lk;
   logic            e_ready, e_err;
`ifdef AUDCLK_SQUARE_OUT_EN
   logic [CH-1:0]   e_sq;
`endif

   function automatic longint unsigned npulse(input int ch, input longint unsigned k);
      return (k * m_inc[ch]) / m_mod[ch];
   endfunction

   task automatic model_reset();
      for (int ch = 0; ch < CH; ch++) begin
         m_en[ch]  = 1'b1;
         m_inc[ch] = D_INC;
         m_mod[ch] = D_MOD;
         m_k[ch]   = 0;
      end
      m_pend  = 1'b0;
      e_ce    = '0;
      e_lk    = '0;
      e_ready = 1'b1;
      e_err   = 1'b0;
`ifdef AUDCLK_SQUARE_OUT_EN
      e_sq    = '0;
`endif
   endtask

   task automatic model_step(input logic v, input logic [CW-1:0] c,
                             input logic [ACC_W-1:0] i, input logic [ACC_W-1:0] m);
      bit do_apply;
      do_apply = m_pend;
      for (int ch = 0; ch < CH; ch++) begin
         if (do_apply && (int'(m_chan) == ch)) begin
            m_k[ch]  = 0;
            e_ce[ch] = 1'b0;
            e_lk[ch] = 1'b0;
`ifdef AUDCLK_SQUARE_OUT_EN
            e_sq[ch] = 1'b0;
`endif
            if (m_ld_inc == 0 || m_ld_inc >= m_ld_mod) begin
               m_en[ch] = 1'b0;
            end else begin
               m_en[ch]  = 1'b1;
               m_inc[ch] = m_ld_inc;
               m_mod[ch] = m_ld_mod;
            end
         end else if (m_en[ch]) begin
            m_k[ch]++;
            e_ce[ch] = (npulse(ch, m_k[ch]) != npulse(ch, m_k[ch] - 1));
            e_lk[ch] = (npulse(ch, m_k[ch] - 1) >= LOCK);
`ifdef AUDCLK_SQUARE_OUT_EN
            e_sq[ch] = (npulse(ch, m_k[ch]) % 2) == 1;
`endif
         end else begin
            e_ce[ch] = 1'b0;
            e_lk[ch] = 1'b0;
`ifdef AUDCLK_SQUARE_OUT_EN
            e_sq[ch] = 1'b0;
`endif
         end
      end
      if (do_apply) begin
         m_pend = 1'b0;
      end else if (v) begin
         m_pend   = 1'b1;
         m_chan   = c;
         m_ld_inc = longint'(i);
         m_ld_mod = longint'(m);
      end
      e_ready = !m_pend;
      e_err   = m_pend && ((int'(m_chan) >= CH) || m_ld_inc == 0 || m_ld_inc >= m_ld_mod);
   endtask

   // per-cycle comparison of every output against the model
   initial begin
      logic             v, r;
      logic [CW-1:0]    c;
      logic [ACC_W-1:0] i, m;
      model_reset();
      forever begin
         @(posedge refclk);
         v = cfg_if.cfg_valid;
         c = cfg_if.cfg_chan;
         i = cfg_if.cfg_inc;
         m = cfg_if.cfg_mod;
         r = rst_n;
         if (!r) model_reset();
         else    model_step(v, c, i, m);
         #1;
         if (mon_on) begin
            check_val("ce",        ce,               e_ce);
            check_val("locked",    locked,           e_lk);
            check_val("cfg_ready", cfg_if.cfg_ready, e_ready);
            check_val("cfg_err",   cfg_if.cfg_err,   e_err);
`ifdef AUDCLK_SQUARE_OUT_EN
            check_val("clk_sq",    clk_sq,           e_sq);
`endif
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge refclk);
   endtask

   task automatic cfg_write(input int chan, input longint unsigned inc, input longint unsigned mod);
      int tries = 0;
      @(negedge refclk);
      while (!cfg_if.cfg_ready && tries < 20) begin
         @(negedge refclk);
         tries++;
      end
      if (!cfg_if.cfg_ready) check_val("cfg_ready_wait", cfg_if.cfg_ready, 1);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_chan  = CW'(chan);
      cfg_if.cfg_inc   = ACC_W'(inc);
      cfg_if.cfg_mod   = ACC_W'(mod);
      @(negedge refclk);
      cfg_if.cfg_valid = 1'b0;
   endtask

   // release reset and verify the default ratio on channel 0 over one full MOD period
   task automatic default_run(input string tag);
      int cnt = 0, first = 0, c16 = 0, lk_first = 0;
      @(negedge refclk);
      rst_n = 1'b1;
      for (int cyc = 1; cyc <= 25000; cyc++) begin
         @(posedge refclk);
         #1;
         if (ce[0]) begin
            cnt++;
            if (cnt == 1)    first = cyc;
            if (cnt == LOCK) c16   = cyc;
         end
         if (locked[0] && lk_first == 0) lk_first = cyc;
      end
      check_val({tag, "_ce0_count"},  cnt,      64'd12288);
      check_val({tag, "_first_ce"},   first,    64'd3);
      check_val({tag, "_16th_ce"},    c16,      (LOCK * D_MOD + D_INC - 1) / D_INC);
      check_val({tag, "_lock_cycle"}, lk_first, (LOCK * D_MOD + D_INC - 1) / D_INC + 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_chan  = '0;
      cfg_if.cfg_inc   = '0;
      cfg_if.cfg_mod   = '0;
      #2 rst_n = 1'b0;
      mon_on = 1'b1;
      tick(3);
      check_val("rst_ce",     ce,               0);
      check_val("rst_locked", locked,           0);
      check_val("rst_ready",  cfg_if.cfg_ready, 1);
      check_val("rst_err",    cfg_if.cfg_err,   0);

      default_run("boot");

      // ch1 to 1/4: one-cycle ready drop, locked[1] falls, ce[1] every 4th step
      cfg_write(1, 1, 4);
      check_val("ch1_apply_ready", cfg_if.cfg_ready, 0);
      check_val("ch1_apply_err",   cfg_if.cfg_err,   0);
      @(negedge refclk);
      check_val("ch1_ready_back",  cfg_if.cfg_ready, 1);
      check_val("ch1_unlocked",    locked[1],        0);
      check_val("ch1_ce_apply",    ce[1],            0);
      for (int s = 1; s <= 16; s++) begin
         @(posedge refclk);
         #1;
         check_val("ch1_quarter", ce[1], (s % 4) == 0);
      end

      // illegal ratios on ch0, then a legal 3/7
      cfg_write(0, 0, 100);
      check_val("ch0_inc0_err", cfg_if.cfg_err, 1);
      @(negedge refclk);
      check_val("ch0_err_pulse", cfg_if.cfg_err, 0);
      tick(30);
      check_val("ch0_dis_locked", locked[0], 0);
      cfg_write(0, 100, 100);
      check_val("ch0_eq_err", cfg_if.cfg_err, 1);
      tick(30);
      check_val("ch0_dis_ce", ce[0], 0);
      cfg_write(0, 3, 7);
      check_val("ch0_legal_err", cfg_if.cfg_err, 0);
      @(negedge refclk);
      cnt = 0;
      for (int s = 1; s <= 70; s++) begin
         @(posedge refclk);
         #1;
         if (ce[0]) cnt++;
      end
      check_val("ch0_3of7_count", cnt, 30);

      // out-of-range channel
      cfg_write(3, 5, 9);
      check_val("badchan_err", cfg_if.cfg_err, 1);
      tick(50);

      // random loads
      for (int n = 0; n < 25; n++) begin
         longint unsigned md, ic;
         int sel;
         md  = longint'($urandom_range(2, 3000));
         sel = int'($urandom_range(0, 9));
         case (sel)
            0:       ic = 0;
            1:       ic = md;
            2:       ic = md + longint'($urandom_range(1, 50));
            default: ic = longint'($urandom_range(1, int'(md) - 1));
         endcase
         cfg_write(int'($urandom_range(0, 3)), ic, md);
         tick(int'($urandom_range(5, 150)));
      end

`ifdef AUDCLK_SQUARE_OUT_EN
      cfg_write(2, 1, 2);
      @(negedge refclk);
      begin
         int toggles = 0;
         logic prev;
         prev = clk_sq[2];
         for (int s = 1; s <= 16; s++) begin
            @(posedge refclk);
            #1;
            if (clk_sq[2] != prev) toggles++;
            prev = clk_sq[2];
         end
         check_val("sq_toggles", toggles, 8);
      end
`endif

      // reset in the middle of an apply
      cfg_write(1, 2, 5);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_apply_ce",     ce,               0);
      check_val("arst_apply_locked", locked,           0);
      check_val("arst_apply_err",    cfg_if.cfg_err,   0);
      check_val("arst_apply_ready",  cfg_if.cfg_ready, 1);
      tick(3);
      @(negedge refclk);
      rst_n = 1'b1;
      tick(200);

      // reset between pulses, then the default sequence must repeat exactly
      @(negedge refclk);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_mid_ce",     ce,     0);
      check_val("arst_mid_locked", locked, 0);
      tick(3);
      default_run("rerun");

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
